// File: rtl/irq_ctrl.sv
// External interrupt controller: synchronised request capture, fixed-priority presentation
// to the picoRV32 irq/eoi ports, and a small register window on the native memory bus.
module irq_ctrl #(
  parameter int unsigned NSRC        = 3,
  parameter int unsigned IRQ_BASE    = 5,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic [31:0]     mem_rdata,
  output logic [31:0]     cpu_irq,
  input  logic [31:0]     cpu_eoi
);

  localparam logic [7:0] OFF_ENABLE  = 8'h00;
  localparam logic [7:0] OFF_PENDING = 8'h04;
  localparam logic [7:0] OFF_MODE    = 8'h08;
  localparam logic [7:0] OFF_ACTIVE  = 8'h0C;
  localparam logic [7:0] OFF_SWTRIG  = 8'h10;

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] idx_oh;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] s_prev;

  logic            sel;
  logic [7:0]      off;
  logic            wr;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] eoi_src;
  logic            eoi_hit;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] set_bits;
  logic [NSRC-1:0] clr_bits;
  logic [NSRC-1:0] act;
  logic [31:0]     rd_val;
  logic            unused_ok;

  assign sel     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign off     = mem_addr[7:0];
  assign wr      = mem_ready && sel && (mem_wstrb != 4'b0000);
  assign s       = sync_q[SYNC_STAGES-1];
  assign eoi_src = cpu_eoi[IRQ_BASE +: NSRC];
  assign eoi_hit = |(eoi_src & idx_oh);
  assign req     = pending & enable;
  // Lowest set bit wins: src[0] has the highest priority.
  assign grant   = req & (~req + NSRC'(1));
  assign act     = (state != IDLE) ? idx_oh : '0;
  assign unused_ok = ^{cpu_eoi, mem_wdata};

  // Edge/SWTRIG sets take precedence over W1C and eoi clears in the same cycle.
  always_comb begin
    set_bits = s & ~s_prev;
    clr_bits = '0;
    if (wr && off == OFF_SWTRIG)  set_bits = set_bits | mem_wdata[NSRC-1:0];
    if (wr && off == OFF_PENDING) clr_bits = mem_wdata[NSRC-1:0];
    if (state == PRESENT && eoi_hit) clr_bits = clr_bits | idx_oh;
    set_bits = set_bits & ~mode;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_ENABLE:  rd_val = 32'(enable);
      OFF_PENDING: rd_val = 32'(pending);
      OFF_MODE:    rd_val = 32'(mode);
      OFF_ACTIVE: begin
        rd_val     = 32'(act);
        rd_val[31] = (state != IDLE);
      end
      default:     rd_val = '0;
    endcase
  end

  // Input synchronisers and edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (mode & s) | (~mode & ((pending & ~clr_bits) | set_bits));
    end
  end

  // Register window: one-cycle ready pulse, write commits on the ready cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      enable    <= '0;
      mode      <= '0;
    end else begin
      mem_ready <= sel && !mem_ready;
      mem_rdata <= (sel && !mem_ready) ? rd_val : '0;
      if (wr && off == OFF_ENABLE) enable <= mem_wdata[NSRC-1:0];
      if (wr && off == OFF_MODE)   mode   <= mem_wdata[NSRC-1:0];
    end
  end

  // Presentation sequencer: one source at a time through the eoi handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx_oh  <= '0;
      cpu_irq <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            idx_oh  <= grant;
            cpu_irq <= 32'(grant) << IRQ_BASE;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (eoi_hit) begin
            cpu_irq <= '0;
            state   <= SERVICE;
          end else if (!(|(idx_oh & enable & pending))) begin
            cpu_irq <= '0;
            idx_oh  <= '0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          cpu_irq <= '0;
          if (!eoi_hit) begin
            idx_oh <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          cpu_irq <= '0;
          idx_oh  <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register vector table plus hand-timed interrupt sequences.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [7:0] R_EN = 8'h00, R_PEND = 8'h04, R_MODE = 8'h08, R_ACT = 8'h0C, R_SW = 8'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  irq_src;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [31:0] cpu_irq;
  logic [31:0] cpu_eoi;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .cpu_irq(cpu_irq), .cpu_eoi(cpu_eoi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] off, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata);
    int n;
    n = 0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | 32'(off);
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 8);
    check("ready_latency", 32'(n), 32'd1);
    rdata = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("ready_pulse", {31'b0, mem_ready}, 32'd0);
    check("rdata_idle", mem_rdata, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus(off, d, 4'hF, dummy);
  endtask

  task automatic rd_check(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus(off, 32'h0, 4'h0, r);
    check(name, r, exp);
  endtask

  task automatic wait_irq(input string name, input logic [31:0] exp, input int budget);
    int n;
    n = 0;
    while (cpu_irq !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, cpu_irq, exp);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; irq_src = '0; mem_valid = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; cpu_eoi = '0;
    tick(3);
    check("rst_irq", cpu_irq, 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    tick(2);

    // Register behaviour with all sources disabled.
    vecs[0]  = '{1'b0, R_EN,   32'h0,         32'h0};
    vecs[1]  = '{1'b0, R_PEND, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, R_MODE, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, R_ACT,  32'h0,         32'h0};
    vecs[4]  = '{1'b1, R_MODE, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, R_MODE, 32'h0,         32'h7};
    vecs[6]  = '{1'b1, R_SW,   32'h7,         32'h0};
    vecs[7]  = '{1'b0, R_PEND, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, R_MODE, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, R_SW,   32'h5,         32'h0};
    vecs[10] = '{1'b0, R_PEND, 32'h0,         32'h5};
    vecs[11] = '{1'b0, R_SW,   32'h0,         32'h0};
    vecs[12] = '{1'b1, R_PEND, 32'h1,         32'h0};
    vecs[13] = '{1'b0, R_PEND, 32'h0,         32'h4};
    vecs[14] = '{1'b1, 8'h40,  32'hFF,        32'h0};
    vecs[15] = '{1'b0, 8'h40,  32'h0,         32'h0};
    vecs[16] = '{1'b1, R_PEND, 32'h4,         32'h0};
    vecs[17] = '{1'b0, R_PEND, 32'h0,         32'h0};
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) wr(vecs[i].off, vecs[i].wdata);
      else rd_check($sformatf("vec%0d", i), vecs[i].off, vecs[i].exp);
    end
    check("tbl_irq_quiet", cpu_irq, 32'd0);

    // 1: single edge source through the full handshake.
    wr(R_EN, 32'h7);
    irq_src[0] = 1'b1;
    wait_irq("t1_present", 32'h20, 5);
    rd_check("t1_pending", R_PEND, 32'h1);
    rd_check("t1_active", R_ACT, 32'h8000_0001);
    tick(25);
    irq_src[0] = 1'b0;
    check("t1_hold", cpu_irq, 32'h20);
    cpu_eoi[5] = 1'b1;
    tick(1);
    check("t1_eoi_drop", cpu_irq, 32'h0);
    rd_check("t1_pend_clr", R_PEND, 32'h0);
    rd_check("t1_service", R_ACT, 32'h8000_0001);
    cpu_eoi[5] = 1'b0;
    tick(2);
    rd_check("t1_idle", R_ACT, 32'h0);

    // 2: simultaneous edges, priority order, re-arbitration after eoi.
    irq_src[2:1] = 2'b11;
    wait_irq("t2_first", 32'h40, 6);
    cpu_eoi[6] = 1'b1;
    tick(1);
    check("t2_eoi_drop", cpu_irq, 32'h0);
    cpu_eoi[6] = 1'b0;
    wait_irq("t2_second", 32'h80, 2);
    cpu_eoi[7] = 1'b1;
    tick(1);
    check("t2_eoi7_drop", cpu_irq, 32'h0);
    cpu_eoi[7] = 1'b0;
    irq_src = '0;
    tick(4);
    check("t2_quiet", cpu_irq, 32'h0);

    // 3: disabled pending, late enable, W1C withdraws the request.
    wr(R_EN, 32'h0);
    irq_src[1] = 1'b1;
    tick(5);
    irq_src[1] = 1'b0;
    tick(3);
    check("t3_masked", cpu_irq, 32'h0);
    rd_check("t3_pending", R_PEND, 32'h2);
    wr(R_EN, 32'h2);
    wait_irq("t3_enable", 32'h40, 1);
    wr(R_PEND, 32'h2);
    wait_irq("t3_w1c_drop", 32'h0, 1);
    rd_check("t3_idle", R_ACT, 32'h0);

    // 4: level mode re-presents while the line stays high.
    wr(R_EN, 32'h1);
    wr(R_MODE, 32'h1);
    irq_src[0] = 1'b1;
    wait_irq("t4_present", 32'h20, 6);
    for (int k = 0; k < 2; k++) begin
      cpu_eoi[5] = 1'b1;
      tick(1);
      check($sformatf("t4_eoi%0d", k), cpu_irq, 32'h0);
      cpu_eoi[5] = 1'b0;
      wait_irq($sformatf("t4_again%0d", k), 32'h20, 2);
    end
    irq_src[0] = 1'b0;
    wait_irq("t4_level_drop", 32'h0, 5);
    rd_check("t4_pending", R_PEND, 32'h0);
    tick(10);
    check("t4_quiet", cpu_irq, 32'h0);
    wr(R_MODE, 32'h0);

    // 5a: edge set coincides with W1C.
    wr(R_EN, 32'h0);
    wr(R_SW, 32'h4);
    rd_check("t5_sw_set", R_PEND, 32'h4);
    irq_src[2] = 1'b1;
    wr(R_PEND, 32'h4);
    rd_check("t5_edge_vs_w1c", R_PEND, 32'h4);
    // 5b: SWTRIG set coincides with the eoi clear.
    wr(R_EN, 32'h4);
    wait_irq("t5_present", 32'h80, 2);
    fork
      wr(R_SW, 32'h4);
      begin
        tick(2);
        cpu_eoi[7] = 1'b1;
      end
    join
    check("t5_service", cpu_irq, 32'h0);
    rd_check("t5_sw_vs_eoi", R_PEND, 32'h4);
    cpu_eoi[7] = 1'b0;
    wait_irq("t5_represent", 32'h80, 2);
    cpu_eoi[7] = 1'b1;
    tick(1);
    cpu_eoi[7] = 1'b0;
    irq_src[2] = 1'b0;
    tick(3);
    rd_check("t5_cleared", R_PEND, 32'h0);

    // 6: reset in SERVICE with eoi still asserted.
    wr(R_EN, 32'h7);
    irq_src[0] = 1'b1;
    tick(4);
    irq_src[0] = 1'b0;
    wait_irq("t6_present", 32'h20, 6);
    cpu_eoi[5] = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(2);
    check("t6_rst_irq", cpu_irq, 32'h0);
    check("t6_rst_ready", {31'b0, mem_ready}, 32'h0);
    check("t6_rst_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    rd_check("t6_active", R_ACT, 32'h0);
    rd_check("t6_pending", R_PEND, 32'h0);
    rd_check("t6_enable", R_EN, 32'h0);
    cpu_eoi[5] = 1'b0;
    wr(R_EN, 32'h2);
    irq_src[1] = 1'b1;
    tick(4);
    irq_src[1] = 1'b0;
    wait_irq("t6_new", 32'h40, 4);
    cpu_eoi[6] = 1'b1;
    tick(1);
    check("t6_eoi_drop", cpu_irq, 32'h0);
    cpu_eoi[6] = 1'b0;
    tick(3);
    rd_check("t6_idle", R_ACT, 32'h0);
    r = cpu_irq;
    check("t6_final_quiet", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
